// File: rtl/mem_access.sv
// mem_access: memory-stage controller between execute and writeback.
// Latency: non-memory op 1 cycle to wb_valid; memory op 1 + REQ cycles until ack.
// Backpressure: stall holds upstream while an access is outstanding; optional macro MEM_ALIGN_CHK_EN rejects misaligned accesses.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] exe_out,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        misalign_err
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Counter value seen in the last REQ cycle allowed before an abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        req_nxt;
  logic        we_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] wdata_nxt;
  logic        wbv_nxt;
  logic [31:0] wbd_nxt;
  logic        berr_nxt;
  logic        merr_nxt;
  logic        stall_c;
  logic        mem_op;
  logic        misaligned;
  logic        timeout_hit;

  assign mem_op = mem_read | mem_write;

`ifdef MEM_ALIGN_CHK_EN
  assign misaligned = (addr_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Last permitted REQ cycle without an ack ends the access with a bus error.
  assign timeout_hit = (cnt == CNT_LAST) && !mem_ack;

  // Stall is forced low while reset is asserted so upstream never sees a stale hold.
  assign stall = stall_c & rst_n;

  // Next-state, next-register values and the combinational stall.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    wbv_nxt   = 1'b0;
    wbd_nxt   = wb_data;
    berr_nxt  = 1'b0;
    merr_nxt  = 1'b0;
    stall_c   = 1'b0;

    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (mem_op) begin
            if (misaligned) begin
              // Rejected without touching the bus; loads still retire with zero.
              merr_nxt = 1'b1;
              if (mem_read) begin
                wbv_nxt = 1'b1;
                wbd_nxt = 32'd0;
              end
            end else begin
              stall_c   = 1'b1;
              state_nxt = REQ;
              cnt_nxt   = 8'd0;
              req_nxt   = 1'b1;
              we_nxt    = ~mem_read;
              addr_nxt  = addr_in;
              wdata_nxt = store_data;
            end
          end else begin
            wbv_nxt = 1'b1;
            wbd_nxt = exe_out;
          end
        end
      end

      REQ: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
          req_nxt   = 1'b0;
          if (!mem_we) begin
            wbv_nxt = 1'b1;
            wbd_nxt = mem_rdata;
          end
        end else if (timeout_hit) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
          req_nxt   = 1'b0;
          berr_nxt  = 1'b1;
          if (!mem_we) begin
            wbv_nxt = 1'b1;
            wbd_nxt = 32'd0;
          end
        end else begin
          stall_c = 1'b1;
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      mem_req      <= req_nxt;
      mem_we       <= we_nxt;
      mem_addr     <= addr_nxt;
      mem_wdata    <= wdata_nxt;
      wb_valid     <= wbv_nxt;
      wb_data      <= wbd_nxt;
      bus_err      <= berr_nxt;
      misalign_err <= merr_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed stimulus for mem_access with an access-level reference model.
// Model tracks one outstanding access and the writeback/error pulses it must produce.
// Outputs are compared on every falling clock edge, plus literal spot checks.
module tb_mem_access;

  localparam int TO = 4;
`ifdef MEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid, mem_read, mem_write, mem_ack;
  logic [31:0] exe_out, addr_in, store_data, mem_rdata;
  logic        stall, mem_req, mem_we, wb_valid, bus_err, misalign_err;
  logic [31:0] mem_addr, mem_wdata, wb_data;

  int checks = 0;
  int errors = 0;
  int req_tot = 0;
  int stall_tot = 0;
  int r0, s0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .exe_out(exe_out), .addr_in(addr_in),
    .store_data(store_data), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_data(wb_data),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  // Reference: one outstanding access plus the pulses due next cycle.
  typedef struct packed {
    logic        active;
    logic        is_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  req_cycle;   // 1-based count of the current REQ cycle
    logic        wbv;
    logic [31:0] wbd;
    logic        berr;
    logic        merr;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t step(input mstate_t s, input logic v, input logic rd,
                                   input logic wr, input logic [31:0] eo,
                                   input logic [31:0] ad, input logic [31:0] sd,
                                   input logic ack, input logic [31:0] rdata);
    mstate_t n;
    n = s;
    n.wbv = 1'b0;
    n.berr = 1'b0;
    n.merr = 1'b0;
    if (s.active) begin
      if (ack) begin
        n.active = 1'b0;
        if (s.is_load) begin n.wbv = 1'b1; n.wbd = rdata; end
      end else if (s.req_cycle == 8'(TO)) begin
        n.active = 1'b0;
        n.berr = 1'b1;
        if (s.is_load) begin n.wbv = 1'b1; n.wbd = 32'd0; end
      end else begin
        n.req_cycle = s.req_cycle + 8'd1;
      end
    end else if (v) begin
      if (rd || wr) begin
        if (ALIGN && ad[1:0] != 2'b00) begin
          n.merr = 1'b1;
          if (rd) begin n.wbv = 1'b1; n.wbd = 32'd0; end
        end else begin
          n.active = 1'b1;
          n.is_load = rd;
          n.addr = ad;
          n.wdata = sd;
          n.req_cycle = 8'd1;
        end
      end else begin
        n.wbv = 1'b1;
        n.wbd = eo;
      end
    end
    return n;
  endfunction

  function automatic logic exp_stall(input mstate_t s, input logic rn, input logic v,
                                     input logic rd, input logic wr,
                                     input logic [31:0] ad, input logic ack);
    if (!rn) return 1'b0;
    if (s.active) return !ack && (s.req_cycle != 8'(TO));
    return v && (rd || wr) && !(ALIGN && ad[1:0] != 2'b00);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= step(m, ex_valid, mem_read, mem_write, exe_out, addr_in, store_data,
                   mem_ack, mem_rdata);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus activity tallies.
  initial begin
    forever begin
      @(negedge clk);
      chk("stall", 32'(stall), 32'(exp_stall(m, rst_n, ex_valid, mem_read, mem_write,
                                             addr_in, mem_ack)));
      chk("mem_req", 32'(mem_req), 32'(m.active));
      chk("wb_valid", 32'(wb_valid), 32'(m.wbv));
      chk("wb_data", wb_data, m.wbd);
      chk("bus_err", 32'(bus_err), 32'(m.berr));
      chk("misalign_err", 32'(misalign_err), 32'(m.merr));
      if (m.active) begin
        chk("mem_we", 32'(mem_we), 32'(!m.is_load));
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_wdata", mem_wdata, m.wdata);
      end
      if (mem_req) req_tot++;
      if (stall) stall_tot++;
    end
  end

  // One cycle of inputs, applied just after the rising edge.
  task automatic cyc(input logic v, input logic rd, input logic wr, input logic [31:0] eo,
                     input logic [31:0] ad, input logic [31:0] sd, input logic ack,
                     input logic [31:0] rdata);
    @(posedge clk);
    #1;
    ex_valid = v; mem_read = rd; mem_write = wr; exe_out = eo;
    addr_in = ad; store_data = sd; mem_ack = ack; mem_rdata = rdata;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    ex_valid = 0; mem_read = 0; mem_write = 0; mem_ack = 0;
    exe_out = 0; addr_in = 0; store_data = 0; mem_rdata = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);

    // Non-memory op: one-cycle forward, no stall, no bus activity.
    cyc(1, 0, 0, 32'h0000_1234, 32'd0, 32'd0, 0, 32'd0);
    r0 = req_tot; s0 = stall_tot;
    idle();
    @(negedge clk);
    chk("nonmem_wb_valid", 32'(wb_valid), 32'd1);
    chk("nonmem_wb_data", wb_data, 32'h0000_1234);
    idle();
    chk("nonmem_stall_cycles", 32'(stall_tot - s0), 32'd0);
    chk("nonmem_req_cycles", 32'(req_tot - r0), 32'd0);

    // Back-to-back non-memory ops.
    cyc(1, 0, 0, 32'h0000_AAAA, 32'd0, 32'd0, 0, 32'd0);
    cyc(1, 0, 0, 32'h0000_BBBB, 32'd0, 32'd0, 0, 32'd0);
    idle();

    // Load acknowledged in the third REQ cycle.
    cyc(1, 1, 0, 32'd0, 32'h100, 32'd0, 0, 32'd0);
    r0 = req_tot; s0 = stall_tot;
    cyc(1, 1, 0, 32'd0, 32'h100, 32'd0, 0, 32'd0);
    @(negedge clk);
    chk("load_mem_addr", mem_addr, 32'h100);
    chk("load_mem_we", 32'(mem_we), 32'd0);
    cyc(1, 1, 0, 32'd0, 32'h100, 32'd0, 0, 32'd0);
    cyc(1, 1, 0, 32'd0, 32'h100, 32'd0, 1, 32'hCAFE_F00D);
    idle();
    @(negedge clk);
    chk("load_wb_valid", 32'(wb_valid), 32'd1);
    chk("load_wb_data", wb_data, 32'hCAFE_F00D);
    idle();
    chk("load_req_cycles", 32'(req_tot - r0), 32'd3);
    chk("load_stall_cycles", 32'(stall_tot - s0), 32'd3);

    // Store with immediate ack, followed directly by a load.
    cyc(1, 0, 1, 32'd0, 32'h200, 32'hA5A5_A5A5, 0, 32'd0);
    r0 = req_tot;
    cyc(1, 0, 1, 32'd0, 32'h200, 32'hA5A5_A5A5, 1, 32'd0);
    @(negedge clk);
    chk("store_mem_we", 32'(mem_we), 32'd1);
    chk("store_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    cyc(1, 1, 0, 32'd0, 32'h300, 32'd0, 0, 32'd0);
    @(negedge clk);
    chk("store_no_wb", 32'(wb_valid), 32'd0);
    chk("next_load_accepted", 32'(stall), 32'd1);
    cyc(1, 1, 0, 32'd0, 32'h300, 32'd0, 1, 32'h1111_2222);
    idle();
    @(negedge clk);
    chk("next_load_wb_data", wb_data, 32'h1111_2222);
    idle();
    chk("store_load_req_cycles", 32'(req_tot - r0), 32'd2);

    // Load timeout: four REQ cycles, then bus error with zero writeback.
    cyc(1, 1, 0, 32'd0, 32'h400, 32'd0, 0, 32'd0);
    r0 = req_tot; s0 = stall_tot;
    for (int i = 0; i < TO; i++) cyc(1, 1, 0, 32'd0, 32'h400, 32'd0, 0, 32'd0);
    @(negedge clk);
    chk("timeout_abort_stall", 32'(stall), 32'd0);
    idle();
    @(negedge clk);
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    chk("timeout_wb_valid", 32'(wb_valid), 32'd1);
    chk("timeout_wb_data", wb_data, 32'd0);
    idle();
    chk("timeout_req_cycles", 32'(req_tot - r0), 32'd4);
    chk("timeout_stall_cycles", 32'(stall_tot - s0), 32'd4);
    @(negedge clk);
    chk("timeout_bus_err_pulse", 32'(bus_err), 32'd0);

    // Store timeout: bus error only.
    for (int i = 0; i <= TO; i++) cyc(1, 0, 1, 32'd0, 32'h404, 32'h0000_DEAD, 0, 32'd0);
    idle();
    @(negedge clk);
    chk("store_to_bus_err", 32'(bus_err), 32'd1);
    chk("store_to_no_wb", 32'(wb_valid), 32'd0);

    // Read and write both set: treated as a load.
    cyc(1, 1, 1, 32'd0, 32'h600, 32'h99, 0, 32'd0);
    cyc(1, 1, 1, 32'd0, 32'h600, 32'h99, 1, 32'h0000_5555);
    @(negedge clk);
    chk("rw_mem_we", 32'(mem_we), 32'd0);
    idle();
    @(negedge clk);
    chk("rw_wb_data", wb_data, 32'h0000_5555);

    // Reset in the middle of an access; a late ack must be ignored.
    cyc(1, 1, 0, 32'd0, 32'h500, 32'd0, 0, 32'd0);
    cyc(1, 1, 0, 32'd0, 32'h500, 32'd0, 0, 32'd0);
    cyc(1, 1, 0, 32'd0, 32'h500, 32'd0, 0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
    ex_valid = 0; mem_read = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(0, 0, 0, 32'd0, 32'd0, 32'd0, 1, 32'h0000_0BAD);
    idle();
    @(negedge clk);
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_ack_mem_req", 32'(mem_req), 32'd0);

    // Misaligned load.
`ifdef MEM_ALIGN_CHK_EN
    cyc(1, 1, 0, 32'd0, 32'h102, 32'd0, 0, 32'd0);
    @(negedge clk);
    chk("misalign_stall", 32'(stall), 32'd0);
    idle();
    @(negedge clk);
    chk("misalign_err", 32'(misalign_err), 32'd1);
    chk("misalign_wb_valid", 32'(wb_valid), 32'd1);
    chk("misalign_wb_data", wb_data, 32'd0);
    chk("misalign_mem_req", 32'(mem_req), 32'd0);
    cyc(1, 0, 1, 32'd0, 32'h201, 32'h1, 0, 32'd0);
    idle();
    @(negedge clk);
    chk("misalign_st_err", 32'(misalign_err), 32'd1);
    chk("misalign_st_no_wb", 32'(wb_valid), 32'd0);
`else
    cyc(1, 1, 0, 32'd0, 32'h102, 32'd0, 0, 32'd0);
    cyc(1, 1, 0, 32'd0, 32'h102, 32'd0, 1, 32'h0000_7777);
    @(negedge clk);
    chk("unaligned_mem_addr", mem_addr, 32'h102);
    idle();
    @(negedge clk);
    chk("unaligned_wb_data", wb_data, 32'h0000_7777);
    chk("unaligned_no_err", 32'(misalign_err), 32'd0);
`endif

    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-stage controller sitting directly after the execute stage.
- Consumes the ALU result, effective address and store data, and drives a multi-cycle data-memory bus with a req/ack handshake.
- Stalls the upstream pipeline until the access completes, then presents writeback data.
- Forwards the ALU result to writeback for non-memory instructions with no stall.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in REQ without mem_ack before the access is aborted; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage presents a valid instruction this cycle.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store (mem_read and mem_write both high is illegal; mem_read wins).
- exe_out  in  32  ALU result from execute.
- addr_in  in  32  effective memory address from execute.
- store_data  in  32  store data from execute.
- stall  out  1  hold the execute stage and everything upstream.
- mem_req  out  1  data-memory request, registered.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  32  memory address, held stable while mem_req is high.
- mem_wdata  out  32  write data, held stable while mem_req is high.
- mem_rdata  in  32  read data, sampled in the cycle mem_ack is high.
- mem_ack  in  1  memory completes the access this cycle.
- wb_valid  out  1  one-cycle pulse: wb_data is valid for register writeback.
- wb_data  out  32  writeback value.
- bus_err  out  1  one-cycle pulse: access aborted on timeout.
- misalign_err  out  1  one-cycle pulse: misaligned access rejected (see Optional Feature).

Behaviour:
- Reset, asynchronous: all outputs 0, FSM to IDLE, timeout counter 0. An in-flight mem_req drops immediately; the pending access is abandoned and no wb_valid is issued.
- States: IDLE, REQ.
- IDLE, memory op accepted (ex_valid & (mem_read | mem_write)):
  - stall=1 combinationally in the same cycle.
  - Latch addr_in into mem_addr, store_data into mem_wdata, and mem_we = ~mem_read.
  - Next state REQ; mem_req=1 from the next cycle.
- IDLE, non-memory op (ex_valid & ~mem_read & ~mem_write):
  - wb_data <= exe_out and wb_valid=1 on the next cycle.
  - No stall.
- IDLE, no op (ex_valid=0): wb_valid=0. wb_data holds its last value.
- REQ: mem_req=1; mem_addr, mem_wdata and mem_we are frozen.
  - stall = ~mem_ack, so upstream advances in the ack cycle.
  - Timeout counter increments every REQ cycle without ack.
- REQ, mem_ack=1:
  - Next state IDLE, mem_req=0 on the next cycle, counter cleared.
  - Load: wb_data <= mem_rdata, wb_valid=1 on the next cycle.
  - Store: wb_valid stays 0.
- REQ, counter == TIMEOUT_CYCLES-1 and no ack:
  - Abort: next state IDLE, mem_req=0, bus_err=1 for one cycle.
  - Load: wb_data=0 and wb_valid=1 in the same cycle as bus_err.
  - stall deasserts in the abort cycle.
- mem_ack while in IDLE: ignored.
- Instruction presented in the ack cycle: not re-accepted, because the FSM is still in REQ. The next instruction is evaluated in the following IDLE cycle.
- Back-to-back memory ops: minimum spacing is 2 cycles (IDLE accept, REQ with immediate ack). There is no pipelining of requests.
- Latency, non-memory op: 1 cycle from ex_valid to wb_valid.
- Latency, memory op: 1 + (cycles in REQ until ack) to wb_valid, i.e. 2 cycles when ack comes in the first REQ cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined: an accepted memory op with addr_in[1:0] != 0 never enters REQ and never asserts mem_req. misalign_err=1 for one cycle on the next cycle. For loads, wb_valid=1 with wb_data=0 in that same cycle. No stall.
- Undefined: no alignment check; the address is passed through unchanged and misalign_err is tied to 0.

Test Plan:
- Non-memory op: ex_valid=1, exe_out=0x0000_1234, no mem_read/mem_write -> next cycle wb_valid=1, wb_data=0x0000_1234; stall never high; mem_req never high.
- Load, ack after 3 REQ cycles: addr_in=0x100, mem_rdata=0xCAFE_F00D -> mem_req high 3 cycles with mem_addr=0x100, mem_we=0; stall high 3 cycles; wb_valid=1, wb_data=0xCAFE_F00D on the cycle after ack.
- Store, immediate ack: addr_in=0x200, store_data=0xA5A5_A5A5 -> mem_req=1, mem_we=1, mem_wdata=0xA5A5_A5A5 for 1 cycle; no wb_valid. A following load is accepted on the next cycle.
- Timeout, TIMEOUT_CYCLES=4, load with no ack -> mem_req high exactly 4 cycles; bus_err=1 and wb_valid=1 with wb_data=0 in the abort cycle; FSM back in IDLE.
- Reset during REQ: rst_n low mid-access -> mem_req, stall and wb_valid go to 0 immediately. After release, a late mem_ack is ignored.
- MEM_ALIGN_CHK_EN defined, load at addr_in=0x102 -> no mem_req; misalign_err=1 and wb_valid=1 with wb_data=0 next cycle.
